// File: rtl/plab2_mem_arb_pkg.sv
// Shared types for the imem/dmem request arbiter.
// Port ids and the tag FIFO entry layout (domain bit under PLAB2_MEM_ARB_DOMAIN_FENCE_EN).
package plab2_mem_arb_pkg;

  localparam logic ARB_PORT_IMEM = 1'b0;
  localparam logic ARB_PORT_DMEM = 1'b1;

  typedef struct packed {
`ifdef PLAB2_MEM_ARB_DOMAIN_FENCE_EN
    logic domain;
`endif
    logic port;
  } arb_tag_t;

  localparam int ARB_TAG_NBITS = $bits(arb_tag_t);

endpackage

// File: rtl/plab2_mem_arb_tag_fifo.sv
// Synchronous tag FIFO, active-low sync reset, extra pointer bit for full/empty.
// Ports: clk, reset, push/push_data, pop, head (oldest), youngest (newest), full, empty.
module plab2_mem_arb_tag_fifo #(
  parameter int p_width = 1,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [p_width-1:0] push_data,
  input  logic               pop,
  output logic [p_width-1:0] head,
  output logic [p_width-1:0] youngest,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(p_depth);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW-1:0]      last_idx;
  logic [p_width-1:0] mem [p_depth];
  logic               do_push;
  logic               do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign last_idx = wr_ptr[AW-1:0] - AW'(1);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign youngest = mem[last_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/plab2_mem_req_arbiter.sv
// Merges imem/dmem requests onto one memory port (round-robin), steers in-order
// responses back by a tag FIFO. Optional macro: PLAB2_MEM_ARB_DOMAIN_FENCE_EN.
module plab2_mem_req_arbiter
  import plab2_mem_arb_pkg::*;
#(
  parameter int p_req_nbits       = 77,
  parameter int p_resp_nbits      = 47,
  parameter int p_max_outstanding = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    domain,
  input  logic [p_req_nbits-1:0]  imemreq_msg,
  input  logic                    imemreq_val,
  output logic                    imemreq_rdy,
  input  logic [p_req_nbits-1:0]  dmemreq_msg,
  input  logic                    dmemreq_val,
  output logic                    dmemreq_rdy,
  output logic [p_resp_nbits-1:0] imemresp_msg,
  output logic                    imemresp_val,
  input  logic                    imemresp_rdy,
  output logic [p_resp_nbits-1:0] dmemresp_msg,
  output logic                    dmemresp_val,
  input  logic                    dmemresp_rdy,
  output logic [p_req_nbits-1:0]  memreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic                    memreq_domain,
  input  logic [p_resp_nbits-1:0] memresp_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy
);

  logic     favour_dmem_q;
  logic     grant_dmem;
  logic     grant_val;
  logic     stall;
  logic     accept;
  logic     pop;
  logic     full;
  logic     empty;
  logic     head_dmem;
  logic     tag_unused;
  arb_tag_t push_tag;
  arb_tag_t head_tag;
  arb_tag_t last_tag;

  assign grant_dmem = dmemreq_val
                   && (!imemreq_val || favour_dmem_q);
  assign grant_val  = imemreq_val || dmemreq_val;

`ifdef PLAB2_MEM_ARB_DOMAIN_FENCE_EN
  // Hold off a domain switch until every older response has drained.
  assign stall = full
              || (!empty && (domain != last_tag.domain));
`else
  assign stall = full;
`endif

  assign memreq_val    = reset && grant_val && !stall;
  assign memreq_msg    = grant_dmem ? dmemreq_msg : imemreq_msg;
  assign memreq_domain = domain;

  assign imemreq_rdy = reset && imemreq_val && !grant_dmem
                    && memreq_rdy && !stall;
  assign dmemreq_rdy = reset && grant_dmem
                    && memreq_rdy && !stall;

  assign accept = memreq_val && memreq_rdy;

  always_comb begin
    push_tag      = '0;
    push_tag.port = grant_dmem ? ARB_PORT_DMEM : ARB_PORT_IMEM;
`ifdef PLAB2_MEM_ARB_DOMAIN_FENCE_EN
    push_tag.domain = domain;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      favour_dmem_q <= 1'b0;
    end else if (accept) begin
      favour_dmem_q <= !grant_dmem;
    end
  end

  assign head_dmem = (head_tag.port == ARB_PORT_DMEM);

  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = reset && memresp_val
                     && !empty && !head_dmem;
  assign dmemresp_val = reset && memresp_val
                     && !empty && head_dmem;

  assign memresp_rdy = reset && !empty
                    && (head_dmem ? dmemresp_rdy : imemresp_rdy);

  assign pop = memresp_val && memresp_rdy;

  assign tag_unused = ^{head_tag, last_tag};

  plab2_mem_arb_tag_fifo #(
    .p_width (ARB_TAG_NBITS),
    .p_depth (p_max_outstanding)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_tag),
    .pop       (pop),
    .head      (head_tag),
    .youngest  (last_tag),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: doc/plab2_mem_req_arbiter.md
Name: plab2_mem_req_arbiter

Overview:
- Sits directly downstream of the pipelined processor's instruction and data memory ports.
- Merges the imem and dmem request streams onto one shared memory request port, tagging every accepted request with the requested security domain.
- Steers in-order memory responses back to the originating port using a small tag FIFO.
- Gives single-ported memory and cache subsystems one req/resp pair per core.

Parameters:
p_req_nbits, 77, memory request message width (8-bit opaque, 32-bit addr, 32-bit data format)
p_resp_nbits, 47, memory response message width (8-bit opaque, 32-bit data format)
p_max_outstanding, 4, tag FIFO depth, i.e. maximum in-flight requests (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
domain  in  1  current processor security domain (processor's req_domain)
imemreq_msg  in  p_req_nbits  instruction request message
imemreq_val  in  1  instruction request valid
imemreq_rdy  out  1  instruction request ready
dmemreq_msg  in  p_req_nbits  data request message
dmemreq_val  in  1  data request valid
dmemreq_rdy  out  1  data request ready
imemresp_msg  out  p_resp_nbits  instruction response message
imemresp_val  out  1  instruction response valid
imemresp_rdy  in  1  instruction response ready
dmemresp_msg  out  p_resp_nbits  data response message
dmemresp_val  out  1  data response valid
dmemresp_rdy  in  1  data response ready
memreq_msg  out  p_req_nbits  merged request to memory
memreq_val  out  1  merged request valid
memreq_rdy  in  1  memory ready
memreq_domain  out  1  domain tag travelling with memreq_msg
memresp_msg  in  p_resp_nbits  memory response (in request order)
memresp_val  in  1  memory response valid
memresp_rdy  out  1  memory response ready

Behaviour:
- Reset (reset==0 at posedge): tag FIFO empty, round-robin pointer = imem-priority. While reset is low, all val/rdy outputs are 0 and messages pass through. Requests or responses in flight when reset is asserted are discarded and are not replayed.
- Request path is combinational, with zero added latency.
  - Grant: if exactly one port is valid, grant it. If both are valid, grant the port the pointer favours.
  - memreq_val = granted val && !fifo_full. memreq_msg is the granted msg, unmodified. memreq_domain = domain.
  - Granted port rdy = memreq_rdy && !fifo_full. Non-granted port rdy = 0.
  - No comb path from memreq_rdy to any val.
- Accept occurs when memreq_val && memreq_rdy. On accept:
  - Push the port id (0=imem, 1=dmem) into the tag FIFO.
  - Set the pointer to favour the other port. The pointer does not change without an accept.
- FIFO full: both req rdys are 0. A push in the same cycle as a pop is NOT allowed when full, so there is no resp-to-req comb path.
- Response path is combinational.
  - FIFO head selects the destination. Destination val = memresp_val && !fifo_empty. Destination msg = memresp_msg. The other port's val = 0.
  - memresp_rdy = !fifo_empty && destination rdy.
  - Pop on memresp handshake.
- FIFO empty: memresp_rdy = 0. A spurious memresp is held and never forwarded.
- Simultaneous accept and pop (not full): both occur, and occupancy is unchanged.
- Pointers wrap modulo p_max_outstanding. An extra count bit distinguishes full from empty.

Optional Feature:
- Macro: PLAB2_MEM_ARB_DOMAIN_FENCE_EN.
- Enabled:
  - A per-entry domain is stored in the tag FIFO.
  - If the FIFO is non-empty and domain differs from the youngest entry's domain, both req rdys and memreq_val are 0 until the FIFO drains.
  - Responses of one domain therefore never interleave with requests of another.
- Disabled: no domain storage and no stall. Domain changes take effect on the next accepted request.

Decomposition:
- Shared package plab2_mem_arb_pkg holds:
  - port-id constants (ARB_PORT_IMEM=0, ARB_PORT_DMEM=1)
  - the tag entry layout (port id, plus a domain bit under the fence macro)
- Sub-module plab2_mem_arb_tag_fifo: a parameterized synchronous FIFO with full/empty outputs and an active-low synchronous reset.

Test Plan:
- Reset low for 2 cycles with both val=1 -> all rdy/val outputs 0. After release, the first grant goes to imem.
- Both ports valid every cycle with memreq_rdy=1 -> grants alternate imem,dmem,imem,dmem. Accepts stop after 4 with no responses (FIFO full), and all rdy=0.
- Issue imem then dmem then imem, return 3 responses with data 0x11,0x22,0x33 -> the responses appear on imem, dmem, imem respectively.
- memresp_val=1 with FIFO empty -> memresp_rdy=0 and no resp val asserted.
- Head=dmem and dmemresp_rdy=0 for 3 cycles -> memresp_rdy=0 and the entry is held. It pops on the cycle dmemresp_rdy rises.
- With the fence enabled: one domain-0 request outstanding, domain switches to 1 -> request stalls until the response pops, then memreq_domain=1 on the next accept.
